// File: rtl/adc_cmd_arbiter_if.sv
// Requester-side and ADC-side streaming signals shared by the command arbiter.
// master = arbiter view, slave = requesters/ADC view.
interface adc_cmd_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*5-1:0] req_channel;
   logic [NREQ-1:0]   req_ack;
   logic [NREQ-1:0]   rsp_valid;
   logic [4:0]        rsp_channel;
   logic [11:0]       rsp_data;
   logic              ADC_C_Valid;
   logic [4:0]        ADC_C_Channel;
   logic              ADC_C_SOP;
   logic              ADC_C_EOP;
   logic              ADC_C_Ready;
   logic              ADC_R_Valid;
   logic [4:0]        ADC_R_Channel;
   logic [11:0]       ADC_R_Data;
   logic              ADC_R_SOP;
   logic              ADC_R_EOP;

   modport master (
      input  req_valid, req_channel, ADC_C_Ready,
      input  ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP,
      output req_ack, rsp_valid, rsp_channel, rsp_data,
      output ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP
   );

   modport slave (
      output req_valid, req_channel, ADC_C_Ready,
      output ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP,
      input  req_ack, rsp_valid, rsp_channel, rsp_data,
      input  ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP
   );
endinterface

// File: rtl/adc_cmd_arbiter.sv
// Round-robin sharing of one ADC command/response port between NREQ requesters;
// an in-order tag FIFO routes each response back to the requester that issued it.
module adc_cmd_arbiter #(
   parameter int NREQ   = 4,
   parameter int IDXW   = 2,
   parameter int MAXOUT = 4
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    enable,
   input  logic                    err_clr,
   adc_cmd_arbiter_if.master       bus,
   output logic [$clog2(MAXOUT):0] outstanding,
   output logic                    err_orphan,
   output logic                    err_mismatch
);
   localparam int AW = $clog2(MAXOUT);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [4:0]      ch_q, ch_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [4:0]      rsp_ch_q, rsp_ch_d;
   logic [11:0]     rsp_data_q, rsp_data_d;
   logic [AW-1:0]   wr_q, wr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            orphan_q, orphan_d;
   logic            mismatch_q, mismatch_d;

   logic [IDXW-1:0] tag_idx_q [MAXOUT];
   logic [4:0]      tag_ch_q  [MAXOUT];

   logic [IDXW-1:0] win;
   logic [IDXW-1:0] cand;
   logic            found;
   logic            grant;
   logic            push;
   logic            pop;
   logic            orphan_ev;
   logic            mismatch_ev;
   logic            unused_rsp_framing;

   assign unused_rsp_framing = bus.ADC_R_SOP ^ bus.ADC_R_EOP;

   // Search starts one past the last winner so a held request cannot starve others.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      cand  = ptr_q;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDXW'((int'(ptr_q) + k) % NREQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // A command still in ISSUE is counted so the tag FIFO can never overflow.
   assign grant = (state_q == IDLE) && enable && found &&
                  ((int'(cnt_q) + int'(state_q == ISSUE)) < MAXOUT);

   assign push        = (state_q == ISSUE) && bus.ADC_C_Ready;
   assign pop         = bus.ADC_R_Valid && (cnt_q != '0);
   assign orphan_ev   = bus.ADC_R_Valid && (cnt_q == '0);
   assign mismatch_ev = pop && (bus.ADC_R_Channel != tag_ch_q[rd_q]);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant) state_d = ISSUE;
         ISSUE:   if (bus.ADC_C_Ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.ADC_C_Valid   = 1'b0;
      bus.ADC_C_SOP     = 1'b0;
      bus.ADC_C_EOP     = 1'b0;
      bus.ADC_C_Channel = '0;
      if (state_q == ISSUE) begin
         bus.ADC_C_Valid   = 1'b1;
         bus.ADC_C_SOP     = 1'b1;
         bus.ADC_C_EOP     = 1'b1;
         bus.ADC_C_Channel = ch_q;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      idx_d = idx_q;
      ch_d  = ch_q;
      ack_d = '0;
      if (grant) begin
         ptr_d      = win;
         idx_d      = win;
         ch_d       = bus.req_channel[int'(win)*5 +: 5];
         ack_d[win] = 1'b1;
      end

      wr_d  = push ? wr_q + 1'b1 : wr_q;
      rd_d  = pop  ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;

      rsp_valid_d = '0;
      rsp_ch_d    = rsp_ch_q;
      rsp_data_d  = rsp_data_q;
      if (pop) begin
         rsp_valid_d[tag_idx_q[rd_q]] = 1'b1;
         rsp_ch_d                     = bus.ADC_R_Channel;
         rsp_data_d                   = bus.ADC_R_Data;
      end

      // A new error event takes priority over a simultaneous clear.
      orphan_d   = orphan_ev   | (orphan_q   & ~err_clr);
      mismatch_d = mismatch_ev | (mismatch_q & ~err_clr);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ptr_q       <= IDXW'(NREQ - 1);
         idx_q       <= '0;
         ch_q        <= '0;
         ack_q       <= '0;
         rsp_valid_q <= '0;
         rsp_ch_q    <= '0;
         rsp_data_q  <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         orphan_q    <= 1'b0;
         mismatch_q  <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         idx_q       <= idx_d;
         ch_q        <= ch_d;
         ack_q       <= ack_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ch_q    <= rsp_ch_d;
         rsp_data_q  <= rsp_data_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         orphan_q    <= orphan_d;
         mismatch_q  <= mismatch_d;
      end
   end

   // Tag storage is only read behind a non-zero count, so it needs no reset.
   always_ff @(posedge CLK) begin
      if (push) begin
         tag_idx_q[wr_q] <= idx_q;
         tag_ch_q[wr_q]  <= ch_q;
      end
   end

   assign bus.req_ack     = ack_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_channel = rsp_ch_q;
   assign bus.rsp_data    = rsp_data_q;
   assign outstanding     = cnt_q;
   assign err_orphan      = orphan_q;
   assign err_mismatch    = mismatch_q;
endmodule

// File: tb/tb_adc_cmd_arbiter.sv
// Bench for adc_cmd_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_adc_cmd_arbiter;
   localparam int NREQ   = 4;
   localparam int IDXW   = 2;
   localparam int MAXOUT = 4;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       enable;
   logic       err_clr;
   logic [2:0] outstanding;
   logic       err_orphan;
   logic       err_mismatch;

   adc_cmd_arbiter_if #(.NREQ(NREQ)) bus ();

   adc_cmd_arbiter #(.NREQ(NREQ), .IDXW(IDXW), .MAXOUT(MAXOUT)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .enable(enable),
      .err_clr(err_clr),
      .bus(bus),
      .outstanding(outstanding),
      .err_orphan(err_orphan),
      .err_mismatch(err_mismatch)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   // Reference model: command in flight, rotation pointer, queue of outstanding tags.
   bit        m_issue;
   int        m_idx, m_ch, m_ptr;
   int        qi[$];
   int        qc[$];
   logic [3:0]  e_ack, e_rsp_valid;
   logic [4:0]  e_rsp_ch;
   logic [11:0] e_rsp_data;
   bit          e_orph, e_mis;

   function automatic void model_reset();
      m_issue = 0; m_idx = 0; m_ch = 0; m_ptr = NREQ - 1;
      qi.delete(); qc.delete();
      e_ack = '0; e_rsp_valid = '0; e_rsp_ch = '0; e_rsp_data = '0;
      e_orph = 0; e_mis = 0;
   endfunction

   function automatic void model_step();
      int n0;
      int hi, hc, w;
      bit orph_ev, mis_ev;
      n0 = qi.size();
      orph_ev = 0; mis_ev = 0; w = -1;
      e_rsp_valid = '0;
      if (bus.ADC_R_Valid) begin
         if (n0 > 0) begin
            hi = qi.pop_front();
            hc = qc.pop_front();
            e_rsp_valid[hi] = 1'b1;
            e_rsp_ch   = bus.ADC_R_Channel;
            e_rsp_data = bus.ADC_R_Data;
            if (hc != int'(bus.ADC_R_Channel)) mis_ev = 1;
         end else begin
            orph_ev = 1;
         end
      end
      e_orph = orph_ev ? 1'b1 : (err_clr ? 1'b0 : e_orph);
      e_mis  = mis_ev  ? 1'b1 : (err_clr ? 1'b0 : e_mis);
      e_ack = '0;
      if (m_issue) begin
         if (bus.ADC_C_Ready) begin
            qi.push_back(m_idx);
            qc.push_back(m_ch);
            m_issue = 0;
         end
      end else if (enable && n0 < MAXOUT) begin
         for (int k = 1; k <= NREQ; k++)
            if (w < 0 && bus.req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         if (w >= 0) begin
            m_issue = 1; m_idx = w; m_ptr = w;
            m_ch = int'(bus.req_channel[5*w +: 5]);
            e_ack[w] = 1'b1;
         end
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("c_valid",   32'(bus.ADC_C_Valid),   32'(m_issue));
      chk("c_channel", 32'(bus.ADC_C_Channel), m_issue ? 32'(m_ch) : 32'd0);
      chk("c_sop",     32'(bus.ADC_C_SOP),     32'(m_issue));
      chk("c_eop",     32'(bus.ADC_C_EOP),     32'(m_issue));
      chk("req_ack",   32'(bus.req_ack),       32'(e_ack));
      chk("rsp_valid", 32'(bus.rsp_valid),     32'(e_rsp_valid));
      if (e_rsp_valid != '0) begin
         chk("rsp_data",    32'(bus.rsp_data),    32'(e_rsp_data));
         chk("rsp_channel", 32'(bus.rsp_channel), 32'(e_rsp_ch));
      end
      chk("outstanding",  32'(outstanding),  32'(qi.size()));
      chk("err_orphan",   32'(err_orphan),   32'(e_orph));
      chk("err_mismatch", 32'(err_mismatch), 32'(e_mis));
   endtask

   task automatic step();
      model_step();
      @(posedge CLK);
      @(negedge CLK);
      compare_all();
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      model_reset();
      #1;
      compare_all();
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   task automatic quiet_inputs();
      bus.req_valid = '0; bus.req_channel = '0; bus.ADC_C_Ready = 1'b0;
      bus.ADC_R_Valid = 1'b0; bus.ADC_R_Channel = '0; bus.ADC_R_Data = '0;
      bus.ADC_R_SOP = 1'b0; bus.ADC_R_EOP = 1'b0;
      enable = 1'b1; err_clr = 1'b0;
   endtask

   initial begin
      RESET = 1'b1;
      quiet_inputs();
      model_reset();
      @(negedge CLK);
      compare_all();
      chk("reset_rsp_data", 32'(bus.rsp_data),    32'd0);
      chk("reset_rsp_ch",   32'(bus.rsp_channel), 32'd0);
      RESET = 1'b0;

      // Single request from requester 1 on channel 5.
      bus.req_valid = 4'b0010; bus.req_channel[9:5] = 5'd5; bus.ADC_C_Ready = 1'b1;
      step();
      chk("single_ack", 32'(bus.req_ack), 32'b0010);
      chk("single_ch",  32'(bus.ADC_C_Channel), 32'd5);
      chk("single_sop", 32'(bus.ADC_C_SOP), 32'd1);
      bus.req_valid = '0;
      step();
      chk("single_out1", 32'(outstanding), 32'd1);
      bus.ADC_R_Valid = 1'b1; bus.ADC_R_Channel = 5'd5; bus.ADC_R_Data = 12'hABC;
      step();
      chk("single_rsp",  32'(bus.rsp_valid), 32'b0010);
      chk("single_data", 32'(bus.rsp_data), 32'hABC);
      chk("single_out0", 32'(outstanding), 32'd0);
      bus.ADC_R_Valid = 1'b0;

      // All four requesting: rotation 0,1,2,3 then FIFO full.
      do_reset();
      bus.req_valid = 4'hF; bus.req_channel = {5'd4, 5'd3, 5'd2, 5'd1}; bus.ADC_C_Ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rr_ack", 32'(bus.req_ack), 32'(1 << k));
         chk("rr_ch",  32'(bus.ADC_C_Channel), 32'(k + 1));
         step();
      end
      for (int k = 0; k < 3; k++) begin
         step();
         chk("full_noack", 32'(bus.req_ack), 32'd0);
         chk("full_out",   32'(outstanding), 32'd4);
      end
      bus.ADC_R_Valid = 1'b1; bus.ADC_R_Channel = 5'd1; bus.ADC_R_Data = 12'h123;
      step();
      chk("full_rsp_oldest", 32'(bus.rsp_valid), 32'b0001);
      bus.ADC_R_Valid = 1'b0;
      step();
      chk("full_next_grant", 32'(bus.req_ack), 32'b0001);
      bus.req_valid = '0;
      step();

      // Orphan, mismatch, clear.
      do_reset();
      bus.ADC_R_Valid = 1'b1; bus.ADC_R_Channel = 5'd3;
      step();
      chk("orphan_flag",  32'(err_orphan), 32'd1);
      chk("orphan_norsp", 32'(bus.rsp_valid), 32'd0);
      bus.ADC_R_Valid = 1'b0;
      bus.req_valid = 4'b0100; bus.req_channel[14:10] = 5'd2; bus.ADC_C_Ready = 1'b1;
      step();
      bus.req_valid = '0;
      step();
      bus.ADC_R_Valid = 1'b1; bus.ADC_R_Channel = 5'd7; bus.ADC_R_Data = 12'h5A5;
      step();
      chk("mis_flag", 32'(err_mismatch), 32'd1);
      chk("mis_rsp",  32'(bus.rsp_valid), 32'b0100);
      chk("mis_data", 32'(bus.rsp_data), 32'h5A5);
      bus.ADC_R_Valid = 1'b0; err_clr = 1'b1;
      step();
      chk("clr_orphan",   32'(err_orphan), 32'd0);
      chk("clr_mismatch", 32'(err_mismatch), 32'd0);
      err_clr = 1'b0;

      // Backpressure: command held stable while Ready is low.
      bus.req_valid = 4'b0001; bus.req_channel[4:0] = 5'd9; bus.ADC_C_Ready = 1'b0;
      step();
      chk("bp_ack", 32'(bus.req_ack), 32'b0001);
      bus.req_valid = '0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("bp_valid", 32'(bus.ADC_C_Valid), 32'd1);
         chk("bp_ch",    32'(bus.ADC_C_Channel), 32'd9);
         chk("bp_ack0",  32'(bus.req_ack), 32'd0);
      end
      bus.ADC_C_Ready = 1'b1;
      step();
      chk("bp_out", 32'(outstanding), 32'd1);

      // enable dropped during ISSUE, then reset with two outstanding.
      bus.req_valid = 4'b1000; bus.req_channel[19:15] = 5'd11; bus.ADC_C_Ready = 1'b0;
      step();
      enable = 1'b0;
      step(); step();
      bus.ADC_C_Ready = 1'b1;
      step();
      chk("en_out2", 32'(outstanding), 32'd2);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("en_nogrant", 32'(bus.ADC_C_Valid), 32'd0);
      end
      bus.req_valid = '0;
      do_reset();
      chk("rst_out0",  32'(outstanding), 32'd0);
      chk("rst_valid", 32'(bus.ADC_C_Valid), 32'd0);
      bus.ADC_R_Valid = 1'b1; bus.ADC_R_Channel = 5'd11;
      step();
      chk("rst_orphan", 32'(err_orphan), 32'd1);
      bus.ADC_R_Valid = 1'b0;

      // Randomized traffic.
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         enable          = ($urandom_range(99) < 90);
         err_clr         = ($urandom_range(99) < 3);
         bus.ADC_C_Ready = ($urandom_range(99) < 60);
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i]) begin
               if (e_ack[i]) begin
                  if ($urandom_range(1) == 0) bus.req_valid[i] = 1'b0;
                  else bus.req_channel[5*i +: 5] = 5'($urandom);
               end
            end else if ($urandom_range(99) < 25) begin
               bus.req_valid[i] = 1'b1;
               bus.req_channel[5*i +: 5] = 5'($urandom);
            end
         end
         if (qi.size() > 0) bus.ADC_R_Valid = ($urandom_range(99) < 35);
         else               bus.ADC_R_Valid = ($urandom_range(99) < 3);
         if (qi.size() > 0 && $urandom_range(99) < 90) bus.ADC_R_Channel = 5'(qc[0]);
         else                                          bus.ADC_R_Channel = 5'($urandom);
         bus.ADC_R_Data = 12'($urandom);
         if ($urandom_range(999) < 2) do_reset();
         else step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
